// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver (start, 8 data LSB first, stop) with a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREQ  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitIdle
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        parity_err_q, parity_err_d;
  logic        par_bad;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
    par_bad      = par_q != ^shift_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Mid start bit: a line back high here was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          rx_data_d   = shift_q;
          frame_err_d = !rx_s;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad;
          rx_valid_d   = rx_s && !par_bad;
`else
          rx_valid_d   = rx_s;
`endif
          state_d = rx_s ? StIdle : StWaitIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitIdle: begin
        // A stuck-low line reports one framing error, not a stream of frames.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s        <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_in;
      rx_s        <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = state_q != StIdle;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table vectors, hand-written corner sequences and a random frame stream
// checked against a byte-level expectation queue for uart_rx.
module tb_uart_rx;

  localparam int DIV = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx #(
    .BAUD_RATE(100000),
    .CLK_FREQ (1000000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters; a pulse wider than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        valid_cnt++;
        got_q.push_back(rx_data);
      end
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (rx_valid || frame_err) begin
        checks++;
        if (rx_valid && frame_err) begin
          errors++;
          $display("FAIL valid_and_frame_err: both high at %0t, required exclusive", $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx_in = b;
    tick(DIV);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_ok);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(data[i]);
    if (PAR) bit_out(par_ok ? ^data : ~^data);
    bit_out(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_ok;
    int         exp_valid;
    int         exp_fe;
    int         exp_pe;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  logic [7:0] last_data;
  int         v0, f0, p0, g0, exp_fe, exp_pe;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1, 0, 0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 0, 1, 0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1, 0, 0};
    vecs[6] = '{8'h07, 1'b1, 1'b0, PAR ? 0 : 1, 0, PAR ? 1 : 0};

    // Reset state
    tick(3);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(5);

    // Table-driven single frames
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_ok);
      rx_in = 1'b1;
      tick(15);
      check($sformatf("vec%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_frame_err", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_parity_err", i), 32'(pe_cnt - p0), 32'(vecs[i].exp_pe));
      check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // Stop bit low, line stuck low: one framing error, busy until line returns high
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    tick(30);
    check("break_busy_low_line", 32'(busy), 32'h1);
    check("break_frame_err", 32'(fe_cnt - f0), 32'h1);
    check("break_valid", 32'(valid_cnt - v0), 32'h0);
    rx_in = 1'b1;
    tick(5);
    check("break_busy_released", 32'(busy), 32'h0);
    tick(10);

    // Three-cycle glitch on idle line is rejected
    v0 = valid_cnt; f0 = fe_cnt;
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(1);
    check("glitch_busy_seen", 32'(busy), 32'h1);
    tick(6);
    check("glitch_busy_cleared", 32'(busy), 32'h0);
    tick(5);
    check("glitch_valid", 32'(valid_cnt - v0), 32'h0);
    check("glitch_frame_err", 32'(fe_cnt - f0), 32'h0);
    check("glitch_rx_data", 32'(rx_data), 32'h3C);

    // Back-to-back frames with no idle gap
    v0 = valid_cnt; g0 = got_q.size();
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    tick(15);
    check("b2b_count", 32'(valid_cnt - v0), 32'd3);
    if (got_q.size() >= g0 + 3) begin
      check("b2b_byte0", 32'(got_q[g0]), 32'h01);
      check("b2b_byte1", 32'(got_q[g0 + 1]), 32'h80);
      check("b2b_byte2", 32'(got_q[g0 + 2]), 32'hFF);
    end

    // Reset during bit 4 of 8'h55 discards the frame
    v0 = valid_cnt; f0 = fe_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'(8'h55 >> i));
    rx_in = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    rst = 1'b0;
    tick(20);
    check("midrst_no_valid", 32'(valid_cnt - v0), 32'h0);
    check("midrst_no_frame_err", 32'(fe_cnt - f0), 32'h0);
    send_frame(8'h0F, 1'b1, 1'b1);
    rx_in = 1'b1;
    tick(15);
    check("midrst_resume_valid", 32'(valid_cnt - v0), 32'h1);
    check("midrst_resume_data", 32'(rx_data), 32'h0F);

    // Random frame stream against a byte-queue expectation
    g0 = got_q.size(); f0 = fe_cnt; p0 = pe_cnt;
    exp_fe = 0; exp_pe = 0;
    last_data = rx_data;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       stop, pok;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      pok  = PAR ? ($urandom_range(0, 4) != 0) : 1'b1;
      gap  = stop ? $urandom_range(0, 15) : $urandom_range(10, 20);
      send_frame(d, stop, pok);
      rx_in = 1'b1;
      tick(gap);
      last_data = d;
      if (stop && pok) exp_q.push_back(d);
      if (!stop) exp_fe++;
      if (!pok) exp_pe++;
    end
    tick(15);
    check("rand_count", 32'(got_q.size() - g0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i < got_q.size()) check($sformatf("rand_byte%0d", i), 32'(got_q[g0 + i]),
                                       32'(exp_q[i]));
    end
    check("rand_frame_err", 32'(fe_cnt - f0), 32'(exp_fe));
    check("rand_parity_err", 32'(pe_cnt - p0), 32'(exp_pe));
    check("rand_last_data", 32'(rx_data), 32'(last_data));
    check("rand_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-002 The block SHALL have parameter CLK_FREQ, default 50000000, clk frequency in Hz.
REQ-003 The block SHALL define BAUD_DIV = CLK_FREQ/BAUD_RATE (integer divide), clk cycles per bit; legal range 4..65535.
REQ-004 Port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port rx_in, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-007 Port rx_data, output, 8 bits: last received byte.
REQ-008 Port rx_valid, output, 1 bit: one-cycle pulse, rx_data holds a good byte.
REQ-009 Port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-010 Port parity_err, output, 1 bit: one-cycle pulse, parity mismatch (see Configuration).
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 rx_in SHALL pass through a two-flop synchronizer; all logic uses the synchronized value (rx_s).
REQ-013 Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-014 States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-015 IDLE -> START on rx_s = 0; the 16-bit baud counter clears to 0.
REQ-016 START: at counter = BAUD_DIV/2 - 1, rx_s = 0 -> DATA, counter cleared; rx_s = 1 -> IDLE (glitch rejected, no flag).
REQ-017 DATA: each time counter = BAUD_DIV - 1, sample rx_s into shift register bit[bit_idx], clear counter, bit_idx++; after bit 7 -> PARITY or STOP.
REQ-018 STOP: at counter = BAUD_DIV - 1, sample rx_s; 1 -> rx_data loaded, rx_valid pulse next cycle, -> IDLE; 0 -> rx_data loaded, frame_err pulse, no rx_valid, -> WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL stay until rx_s = 1, then -> IDLE (break / stuck-low line is one error, not repeated frames).
REQ-020 rx_valid and frame_err SHALL never assert in the same cycle; each is exactly one clk wide.
REQ-021 rx_data SHALL change only when a stop bit is sampled; held otherwise.
REQ-022 Latency: rx_valid SHALL rise 1 cycle after the stop-bit mid-sample, about 9.5 bit times (10.5 with parity) after the start-bit falling edge at the synchronizer output.
REQ-023 A new falling edge SHALL be accepted in the cycle IDLE is re-entered; back-to-back frames with no idle gap are received without loss.
REQ-024 Line activity outside IDLE other than at sample points SHALL be ignored.

Reset
REQ-025 rst SHALL immediately force state IDLE, counter 0, bit_idx 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, frame_err 0, parity_err 0, busy 0.
REQ-026 rst asserted mid-frame SHALL discard the partial byte with no pulse; after release, reception resumes at the next falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: a PARITY state between DATA and STOP samples one even-parity bit at the same mid-bit point.
REQ-028 With the macro, on a mismatch parity_err pulses with the stop-bit result and rx_valid is suppressed; frame_err still reports independently.
REQ-029 Without the macro: no PARITY state, frame is 10 bits, parity_err tied 0.

Verification (CLK_FREQ=1000000, BAUD_RATE=100000, BAUD_DIV=10)
REQ-030 Send 8'hA5, stop = 1 -> one rx_valid pulse, rx_data = 8'hA5, frame_err 0, busy low afterwards.
REQ-031 Send 8'h3C with stop = 0, line then held low 30 cycles, then high -> frame_err single pulse, no rx_valid, busy low only after line returns high.
REQ-032 Low glitch of 3 cycles on idle line -> no pulses, busy returns 0 within 7 cycles, rx_data unchanged.
REQ-033 Frames 8'h01, 8'h80, 8'hFF back-to-back, no idle gap -> three rx_valid pulses in order with matching rx_data.
REQ-034 rst for 1 cycle during bit 4 of 8'h55, then send 8'h0F -> no pulse for the aborted frame, rx_data = 8'h0F after the second frame.
REQ-035 With UART_RX_PARITY_EN: 8'h07 with parity 1 -> rx_valid; 8'h07 with parity 0 -> parity_err pulse, no rx_valid.
